// File: rtl/dac_transmision.sv
// dac_transmision: serialises a 16-bit DAC frame {00,pd_mode,data_In} MSB first under an active-low SYNC.
module dac_transmision #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [11:0] data_In,
  input  logic [1:0]  pd_mode,
  output logic        SYNC,
  output logic        DIN,
  output logic        tx_busy,
  output logic        tx_done_tick,
  output logic [15:0] b_reg
);
  typedef enum logic [1:0] {idle, envio, espera} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t state, state_next;
  logic [15:0] b_next;
  logic [3:0] cnt, cnt_next;
  always_ff @(posedge SCLK) begin
    if (reset) begin
      state <= idle;
      b_reg <= 16'h0000;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      b_reg <= b_next;
      cnt   <= cnt_next;
    end
  end
  always_comb begin
    state_next = state;
    b_next     = b_reg;
    cnt_next   = cnt;
    case (state)
      idle:
        if (tx_start) begin
          state_next = envio;
          b_next     = {2'b00, pd_mode, data_In};
          cnt_next   = 4'd0;
        end
      envio: begin
        b_next   = {b_reg[14:0], 1'b0};
        cnt_next = cnt + 4'd1;
        if (cnt == 4'd15) begin
          state_next = espera;
          cnt_next   = 4'd0;
        end
      end
      espera: begin
        // the counter is reused as the gap timer; out-of-range values fall back to idle
        cnt_next = cnt + 4'd1;
        if (cnt >= GAP_LAST) begin
          state_next = idle;
          cnt_next   = 4'd0;
        end
      end
      default: begin
        state_next = idle;
        cnt_next   = 4'd0;
      end
    endcase
  end
  assign SYNC         = state != envio;
  assign DIN          = state == envio && b_reg[15];
  assign tx_busy      = state != idle;
  assign tx_done_tick = state == espera && cnt == 4'd0;
endmodule
